icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_line_ram.sv | 50 +++++
 rtl/icache.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: default geometry and FSM state encoding.
package icache_pkg;

    localparam int ICACHE_INDEX_BITS  = 6;
    localparam int ICACHE_OFFSET_BITS = 2;
    localparam int ICACHE_ADDR_BITS   = 18;
    localparam int ICACHE_TAG_BITS    = ICACHE_ADDR_BITS - 2 - ICACHE_OFFSET_BITS - ICACHE_INDEX_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/icache_line_ram.sv
// Data and tag storage for the direct-mapped instruction cache.
// One write port (fill side) and one read port (lookup side).
module icache_line_ram
    import icache_pkg::*;
#(
    parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
    parameter int OFFSET_BITS = ICACHE_OFFSET_BITS,
    parameter int TAG_BITS    = ICACHE_TAG_BITS
) (
    input  logic                   clk,
    input  logic                   rd_en,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic [31:0]            rd_data,
    output logic [TAG_BITS-1:0]    rd_tag,
    input  logic                   wr_en,
    input  logic                   tag_wr_en,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic [31:0]            wr_data,
    input  logic [TAG_BITS-1:0]    wr_tag
);

    localparam int WORDS = 1 << (INDEX_BITS + OFFSET_BITS);
    localparam int LINES = 1 << INDEX_BITS;

    logic [31:0]         data_mem [0:WORDS-1];
    logic [TAG_BITS-1:0] tag_mem  [0:LINES-1];
    logic [31:0]         rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= data_mem[{rd_index, rd_offset}];
        end
    end

    always_ff @(posedge clk) begin
        if (tag_wr_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    // Tag is read combinationally so hit/miss resolves in the accept cycle.
    assign rd_tag  = tag_mem[rd_index];
    assign rd_data = rd_data_reg;

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with line fill from a word-serial memory port.
// Define ICACHE_FWD_EN to forward the requested word during the fill instead of after it.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
    parameter int OFFSET_BITS = ICACHE_OFFSET_BITS,
    parameter int ADDR_BITS   = ICACHE_ADDR_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] addr,
    input  logic        rn,
    input  logic        flush,
    output logic [31:0] Inst,
    output logic        Read_ready,
    output logic [31:0] mem_addr,
    output logic        mem_rn,
    input  logic [31:0] mem_data,
    input  logic        mem_ready
);

    localparam int LINE_LSB = 2 + OFFSET_BITS;
    localparam int TAG_LSB  = LINE_LSB + INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - TAG_LSB;
    localparam int LINES    = 1 << INDEX_BITS;

    state_t                 state_reg, state_next;
    logic [OFFSET_BITS-1:0] counter_reg, counter_next;
    logic [31:0]            mem_addr_reg, mem_addr_next;
    logic                   mem_rn_reg, mem_rn_next;
    logic [LINES-1:0]       valid_reg, valid_next;
    logic [INDEX_BITS-1:0]  req_index_reg, req_index_next;
    logic [OFFSET_BITS-1:0] req_offset_reg, req_offset_next;
    logic [TAG_BITS-1:0]    req_tag_reg, req_tag_next;
    logic [31:0]            inst_reg, inst_next;
    logic                   rr_fill_reg, rr_fill_next;
    logic                   hit_pend_reg, hit_pend_next;

    logic [INDEX_BITS-1:0]  addr_index;
    logic [OFFSET_BITS-1:0] addr_offset;
    logic [TAG_BITS-1:0]    addr_tag;
    logic [31:0]            ram_rd_data;
    logic [TAG_BITS-1:0]    ram_rd_tag;
    logic                   data_we;
    logic                   tag_we;
    logic                   hit;
    logic                   accept;
    logic                   last_beat;
    logic                   unused_addr_bits;

    assign addr_index       = addr[TAG_LSB-1:LINE_LSB];
    assign addr_offset      = addr[LINE_LSB-1:2];
    assign addr_tag         = addr[ADDR_BITS-1:TAG_LSB];
    assign unused_addr_bits = ^addr[1:0];

    icache_line_ram #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_BITS    (TAG_BITS)
    ) u_line_ram (
        .clk       (clk),
        .rd_en     (rdy),
        .rd_index  (addr_index),
        .rd_offset (addr_offset),
        .rd_data   (ram_rd_data),
        .rd_tag    (ram_rd_tag),
        .wr_en     (data_we & rdy),
        .tag_wr_en (tag_we & rdy),
        .wr_index  (req_index_reg),
        .wr_offset (counter_reg),
        .wr_data   (mem_data),
        .wr_tag    (req_tag_reg)
    );

    assign Read_ready = rr_fill_reg | hit_pend_reg;
    // On a hit the word comes straight from the RAM's registered read port.
    assign Inst       = hit_pend_reg ? ram_rd_data : inst_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_rn     = mem_rn_reg;

    assign hit       = valid_reg[addr_index] && (ram_rd_tag == addr_tag);
    assign accept    = (state_reg == IDLE) && rn && !Read_ready && !flush;
    assign last_beat = (counter_reg == {OFFSET_BITS{1'b1}});

    always_comb begin
        state_next      = state_reg;
        counter_next    = counter_reg;
        mem_addr_next   = mem_addr_reg;
        mem_rn_next     = mem_rn_reg;
        valid_next      = valid_reg;
        req_index_next  = req_index_reg;
        req_offset_next = req_offset_reg;
        req_tag_next    = req_tag_reg;
        inst_next       = inst_reg;
        rr_fill_next    = 1'b0;
        hit_pend_next   = 1'b0;
        data_we         = 1'b0;
        tag_we          = 1'b0;

        if (flush) begin
            // Abandoned fill leaves its line invalid because all valids drop here.
            valid_next   = '0;
            state_next   = IDLE;
            mem_rn_next  = 1'b0;
            counter_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        req_index_next  = addr_index;
                        req_offset_next = addr_offset;
                        req_tag_next    = addr_tag;
                        if (hit) begin
                            hit_pend_next = 1'b1;
                        end else begin
                            state_next    = FILL;
                            mem_rn_next   = 1'b1;
                            mem_addr_next = {addr[31:LINE_LSB], {LINE_LSB{1'b0}}};
                            counter_next  = '0;
                        end
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        data_we       = 1'b1;
                        counter_next  = counter_reg + OFFSET_BITS'(1);
                        mem_addr_next = mem_addr_reg + 32'd4;
                        if (counter_reg == req_offset_reg) begin
                            inst_next = mem_data;
                        end
`ifdef ICACHE_FWD_EN
                        rr_fill_next = (counter_reg == req_offset_reg);
`else
                        rr_fill_next = last_beat;
`endif
                        if (last_beat) begin
                            tag_we                    = 1'b1;
                            valid_next[req_index_reg] = 1'b1;
                            mem_rn_next               = 1'b0;
                            state_next                = IDLE;
                        end
                    end
                end
                default: begin
                    state_next  = IDLE;
                    mem_rn_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            counter_reg    <= '0;
            mem_addr_reg   <= '0;
            mem_rn_reg     <= 1'b0;
            valid_reg      <= '0;
            req_index_reg  <= '0;
            req_offset_reg <= '0;
            req_tag_reg    <= '0;
            inst_reg       <= '0;
            rr_fill_reg    <= 1'b0;
            hit_pend_reg   <= 1'b0;
        end else if (rdy) begin
            state_reg      <= state_next;
            counter_reg    <= counter_next;
            mem_addr_reg   <= mem_addr_next;
            mem_rn_reg     <= mem_rn_next;
            valid_reg      <= valid_next;
            req_index_reg  <= req_index_next;
            req_offset_reg <= req_offset_next;
            req_tag_reg    <= req_tag_next;
            inst_reg       <= inst_next;
            rr_fill_reg    <= rr_fill_next;
            hit_pend_reg   <= hit_pend_next;
        end
    end

endmodule
